mem_port_arbiter: RTL and testbench

//  Shares one single-ported, multicycle memory between the fetch stage (read-only

---
 rtl/mem_port_arbiter.sv | 146 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one single-ported multicycle memory between the fetch
//               stage (instruction reads) and the MEM stage (loads/stores).
//               One transaction is in flight at a time; data requests win over
//               fetches. A flushed fetch still completes on the memory side,
//               but its data is dropped. A watchdog abandons an access that
//               never completes and raises a sticky error flag.
// Ports       : clk, rst             - clock, asynchronous active-high reset
//               instr_*_i / instr_*_o - fetch request, flush, done/data/stall
//               data_*_i  / data_*_o  - MEM-stage request, done/data/stall
//               mem_*_i   / mem_*_o   - memory issue strobes, address/data,
//                                       stall and completion
//               busy_o, err_o         - access in flight, sticky watchdog flag
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_req_i,
  input  logic [15:0] instr_addr_i,
  input  logic        instr_flush_i,
  input  logic        data_req_i,
  input  logic        data_wr_i,
  input  logic [15:0] data_addr_i,
  input  logic [15:0] data_wdata_i,
  input  logic        mem_stall_i,
  input  logic        mem_done_i,
  input  logic [15:0] mem_rdata_i,
  output logic        mem_rd_o,
  output logic        mem_wr_o,
  output logic [15:0] mem_addr_o,
  output logic [15:0] mem_wdata_o,
  output logic        instr_done_o,
  output logic [15:0] instr_rdata_o,
  output logic        instr_stall_o,
  output logic        data_done_o,
  output logic [15:0] data_rdata_o,
  output logic        data_stall_o,
  output logic        busy_o,
  output logic        err_o
);

  localparam logic [1:0] c_IDLE   = 2'd0;
  localparam logic [1:0] c_BUSY_I = 2'd1;
  localparam logic [1:0] c_BUSY_D = 2'd2;
  localparam logic [3:0] c_TIMEOUT = 4'(TIMEOUT_CYCLES);

  logic [1:0] state_q, state_d;
  logic       abort_q, abort_d;
  logic [3:0] wait_cnt_q, wait_cnt_d;
  logic       err_q, err_d;

  logic w_idle;
  logic w_store;
  logic w_issue;
  logic w_timeout;
  logic w_instr_done;
  logic w_data_done;

  assign w_idle  = (state_q == c_IDLE);
  assign w_store = data_req_i & data_wr_i;

  // Issue is decided combinationally in IDLE; held off while reset is asserted
  // so that every strobe is quiet during reset.
  assign w_issue = w_idle & ~rst & ~mem_stall_i & (data_req_i | instr_req_i);

  // Fires on the busy cycle whose increment would make the count reach the limit.
  assign w_timeout = ~w_idle & ~mem_done_i & ((wait_cnt_q + 4'd1) == c_TIMEOUT);

  // A flush arriving together with mem_done must also suppress the completion,
  // hence the direct use of instr_flush_i besides the registered abort.
  assign w_instr_done = (state_q == c_BUSY_I) & mem_done_i & ~abort_q & ~instr_flush_i;
  assign w_data_done  = (state_q == c_BUSY_D) & mem_done_i;

  // Data side wins the issue because MEM holds the older instruction.
  assign mem_rd_o    = w_issue & ~w_store;
  assign mem_wr_o    = w_issue & w_store;
  assign mem_addr_o  = data_req_i  ? data_addr_i  :
                       instr_req_i ? instr_addr_i : 16'h0000;
  assign mem_wdata_o = w_store ? data_wdata_i : 16'h0000;

  assign instr_done_o  = w_instr_done;
  assign instr_rdata_o = w_instr_done ? mem_rdata_i : 16'h0000;
  assign instr_stall_o = instr_req_i & ~w_instr_done;
  assign data_done_o   = w_data_done;
  assign data_rdata_o  = w_data_done ? mem_rdata_i : 16'h0000;
  assign data_stall_o  = data_req_i & ~w_data_done;
  assign busy_o        = ~w_idle;
  assign err_o         = err_q;

  always_comb begin
    state_d    = state_q;
    abort_d    = abort_q;
    wait_cnt_d = wait_cnt_q;
    err_d      = err_q;
    case (state_q)
      c_IDLE: begin
        abort_d = 1'b0;
        if (w_issue) begin
          state_d    = data_req_i ? c_BUSY_D : c_BUSY_I;
          wait_cnt_d = 4'd0;
        end
      end
      c_BUSY_I, c_BUSY_D: begin
        if (mem_done_i) begin
          state_d = c_IDLE;
          abort_d = 1'b0;
        end else begin
          wait_cnt_d = wait_cnt_q + 4'd1;
          if (w_timeout) begin
            // Abandon the access; the still-held request re-arbitrates from IDLE.
            state_d = c_IDLE;
            abort_d = 1'b0;
            err_d   = 1'b1;
          end else if ((state_q == c_BUSY_I) && instr_flush_i) begin
            abort_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = c_IDLE;
        abort_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= c_IDLE;
      abort_q    <= 1'b0;
      wait_cnt_q <= 4'd0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      abort_q    <= abort_d;
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Self-checking bench for mem_port_arbiter. A transaction-level
//               model tracks which access is outstanding, whether it was
//               flushed, how long it has waited and the error flag, and every
//               cycle the DUT outputs are compared against it. Directed
//               scenarios pin the model with literal expectations, followed
//               by a randomized phase with a latency-randomizing memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  localparam int TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_req, instr_flush, data_req, data_wr, mem_stall, mem_done;
  logic [15:0] instr_addr, data_addr, data_wdata, mem_rdata;
  logic        mem_rd, mem_wr, instr_done, instr_stall, data_done, data_stall, busy, err;
  logic [15:0] mem_addr, mem_wdata, instr_rdata, data_rdata;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk           (clk),
    .rst           (rst),
    .instr_req_i   (instr_req),
    .instr_addr_i  (instr_addr),
    .instr_flush_i (instr_flush),
    .data_req_i    (data_req),
    .data_wr_i     (data_wr),
    .data_addr_i   (data_addr),
    .data_wdata_i  (data_wdata),
    .mem_stall_i   (mem_stall),
    .mem_done_i    (mem_done),
    .mem_rdata_i   (mem_rdata),
    .mem_rd_o      (mem_rd),
    .mem_wr_o      (mem_wr),
    .mem_addr_o    (mem_addr),
    .mem_wdata_o   (mem_wdata),
    .instr_done_o  (instr_done),
    .instr_rdata_o (instr_rdata),
    .instr_stall_o (instr_stall),
    .data_done_o   (data_done),
    .data_rdata_o  (data_rdata),
    .data_stall_o  (data_stall),
    .busy_o        (busy),
    .err_o         (err)
  );

  // Transaction-level model: outstanding access kind (0 none, 1 fetch, 2 data),
  // flushed flag, busy cycles waited, sticky error.
  int m_kind  = 0;
  bit m_abort = 1'b0;
  int m_age   = 0;
  bit m_err   = 1'b0;

  // Expectations for the current cycle, also used by the stimulus environment.
  bit e_issue, e_idone, e_ddone, e_timeout;
  int e_kind;

  // Memory environment: cycles until mem_done, 0 means nothing scheduled.
  int cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at time %0t", name, act, exp, $time);
    end
  endtask

  // Compare on the falling edge, away from the active edge.
  task automatic sample();
    @(negedge clk);
    if (rst) begin
      e_issue   = 1'b0;
      e_idone   = 1'b0;
      e_ddone   = 1'b0;
      e_timeout = 1'b0;
      e_kind    = 0;
      chk("rst_busy", busy, 0);
      chk("rst_mem_rd", mem_rd, 0);
      chk("rst_mem_wr", mem_wr, 0);
      chk("rst_instr_done", instr_done, 0);
      chk("rst_data_done", data_done, 0);
      chk("rst_err", err, 0);
    end else begin
      e_kind    = data_req ? 2 : 1;
      e_issue   = (m_kind == 0) && !mem_stall && (data_req || instr_req);
      e_idone   = (m_kind == 1) && mem_done && !m_abort && !instr_flush;
      e_ddone   = (m_kind == 2) && mem_done;
      e_timeout = (m_kind != 0) && !mem_done && (m_age + 1 >= TIMEOUT);
      chk("busy", busy, m_kind != 0);
      chk("mem_rd", mem_rd, e_issue && !(e_kind == 2 && data_wr));
      chk("mem_wr", mem_wr, e_issue && e_kind == 2 && data_wr);
      if (e_issue) begin
        chk("mem_addr", mem_addr, (e_kind == 2) ? data_addr : instr_addr);
        if (e_kind == 2 && data_wr) chk("mem_wdata", mem_wdata, data_wdata);
      end
      if (!instr_req && !data_req) begin
        chk("idle_addr", mem_addr, 0);
        chk("idle_wdata", mem_wdata, 0);
      end
      chk("instr_done", instr_done, e_idone);
      chk("data_done", data_done, e_ddone);
      if (e_idone) chk("instr_rdata", instr_rdata, mem_rdata);
      if (e_ddone && !data_wr) chk("data_rdata", data_rdata, mem_rdata);
      chk("err", err, m_err);
    end
    chk("instr_stall", instr_stall, instr_req && !e_idone);
    chk("data_stall", data_stall, data_req && !e_ddone);
  endtask

  // Apply this cycle's effect to the model, then move to just after the next edge.
  task automatic advance();
    if (rst) begin
      m_kind = 0; m_abort = 1'b0; m_age = 0; m_err = 1'b0;
    end else if (m_kind == 0) begin
      if (e_issue) begin
        m_kind = e_kind; m_age = 0; m_abort = 1'b0;
      end
    end else if (mem_done) begin
      m_kind = 0; m_abort = 1'b0;
    end else begin
      m_age++;
      if (m_age >= TIMEOUT) begin
        m_err = 1'b1; m_kind = 0; m_abort = 1'b0;
      end else if (m_kind == 1 && instr_flush) begin
        m_abort = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic env_drive();
    rst         = ($urandom_range(0, 499) == 0);
    mem_stall   = ($urandom_range(0, 3) == 0);
    mem_rdata   = 16'($urandom);
    instr_flush = ($urandom_range(0, 7) == 0);
    if (cnt > 0) begin
      cnt--;
      mem_done = (cnt == 0);
    end else begin
      // Occasional spurious completion while nothing is outstanding.
      mem_done = (m_kind == 0) && ($urandom_range(0, 15) == 0);
    end
    if (!instr_req && $urandom_range(0, 2) == 0) begin
      instr_req  = 1'b1;
      instr_addr = 16'($urandom);
    end
    if (!data_req && $urandom_range(0, 3) == 0) begin
      data_req   = 1'b1;
      data_wr    = 1'($urandom_range(0, 1));
      data_addr  = 16'($urandom);
      data_wdata = 16'($urandom);
    end
  endtask

  task automatic env_react();
    if (rst) begin
      cnt = 0;
    end else begin
      if (e_issue) cnt = ($urandom_range(0, 11) == 0) ? 0 : $urandom_range(1, 5);
      if (e_timeout) cnt = 0;
      if (e_idone) instr_req = 1'b0;
      if (e_ddone) data_req = 1'b0;
      if (instr_req && instr_flush && $urandom_range(0, 1) == 1) instr_addr = 16'($urandom);
    end
  endtask

  initial begin
    int nstall;
    int nb;
    bit seen_idle;

    rst = 1'b1; instr_req = 1'b0; instr_flush = 1'b0; data_req = 1'b0; data_wr = 1'b0;
    mem_stall = 1'b0; mem_done = 1'b0; instr_addr = 16'h0; data_addr = 16'h0;
    data_wdata = 16'h0; mem_rdata = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    sample();
    advance();
    rst = 1'b0;

    // 1: single fetch, completion three cycles after issue
    instr_req = 1'b1; instr_addr = 16'h0010; nstall = 0;
    sample(); chk("t1_rd", mem_rd, 1); chk("t1_addr", mem_addr, 16'h0010);
    nstall += int'(instr_stall); advance();
    sample(); chk("t1_rd_once", mem_rd, 0); nstall += int'(instr_stall); advance();
    sample(); nstall += int'(instr_stall); advance();
    mem_done = 1'b1; mem_rdata = 16'h1234;
    sample(); chk("t1_done", instr_done, 1); chk("t1_rdata", instr_rdata, 16'h1234);
    chk("t1_stall_low", instr_stall, 0); chk("t1_stall_cycles", nstall, 3); advance();
    instr_req = 1'b0; mem_done = 1'b0;
    sample(); chk("t1_idle", busy, 0); advance();

    // 2: simultaneous requests, store first, then the fetch after an IDLE cycle
    data_req = 1'b1; data_wr = 1'b1; data_addr = 16'h0200; data_wdata = 16'hBEEF;
    instr_req = 1'b1; instr_addr = 16'h0020;
    sample(); chk("t2_wr", mem_wr, 1); chk("t2_rd", mem_rd, 0);
    chk("t2_addr", mem_addr, 16'h0200); chk("t2_wdata", mem_wdata, 16'hBEEF); advance();
    mem_done = 1'b1;
    sample(); chk("t2_ddone", data_done, 1); chk("t2_idone", instr_done, 0); advance();
    data_req = 1'b0; mem_done = 1'b0;
    sample(); chk("t2_gap_idle", busy, 0); chk("t2_fetch_rd", mem_rd, 1);
    chk("t2_fetch_addr", mem_addr, 16'h0020); advance();
    mem_done = 1'b1; mem_rdata = 16'hCAFE;
    sample(); chk("t2_idone2", instr_done, 1); chk("t2_irdata", instr_rdata, 16'hCAFE); advance();
    instr_req = 1'b0; mem_done = 1'b0;

    // 3: fetch flushed one cycle after issue, completion dropped, refetch
    instr_req = 1'b1; instr_addr = 16'h0030;
    sample(); chk("t3_rd", mem_rd, 1); advance();
    instr_flush = 1'b1; instr_addr = 16'h0040;
    sample(); chk("t3_busy", busy, 1); advance();
    instr_flush = 1'b0;
    sample(); advance();
    sample(); advance();
    mem_done = 1'b1;
    sample(); chk("t3_dropped", instr_done, 0); chk("t3_stall", instr_stall, 1); advance();
    mem_done = 1'b0;
    sample(); chk("t3_gap_idle", busy, 0); chk("t3_refetch", mem_rd, 1);
    chk("t3_refetch_addr", mem_addr, 16'h0040); advance();
    mem_done = 1'b1;
    sample(); chk("t3_done", instr_done, 1); advance();
    instr_req = 1'b0; mem_done = 1'b0;

    // 4: memory stalls a load for five cycles
    data_req = 1'b1; data_wr = 1'b0; data_addr = 16'h0300; mem_stall = 1'b1;
    for (int k = 0; k < 5; k++) begin
      sample(); chk("t4_no_rd", mem_rd, 0); chk("t4_no_wr", mem_wr, 0);
      chk("t4_dstall", data_stall, 1); advance();
    end
    mem_stall = 1'b0;
    sample(); chk("t4_rd", mem_rd, 1); chk("t4_addr", mem_addr, 16'h0300); advance();
    mem_done = 1'b1; mem_rdata = 16'h5A5A;
    sample(); chk("t4_done", data_done, 1); chk("t4_rdata", data_rdata, 16'h5A5A); advance();
    data_req = 1'b0; mem_done = 1'b0;

    // 5: completion never returned, watchdog fires, request re-issues
    instr_req = 1'b1; instr_addr = 16'h0050;
    sample(); chk("t5_issue", mem_rd, 1); advance();
    nb = 0; seen_idle = 1'b0;
    for (int k = 0; k < 40 && !seen_idle; k++) begin
      sample();
      if (busy) begin
        nb++;
        advance();
      end else begin
        seen_idle = 1'b1;
      end
    end
    if (!seen_idle) sample();
    chk("t5_busy_cycles", nb, TIMEOUT);
    chk("t5_err", err, 1); chk("t5_reissue", mem_rd, 1); chk("t5_reissue_addr", mem_addr, 16'h0050);
    advance();
    mem_done = 1'b1;
    sample(); chk("t5_retry_done", instr_done, 1); chk("t5_err_hold", err, 1); advance();
    mem_done = 1'b0; instr_req = 1'b0;
    sample(); chk("t5_err_sticky", err, 1); advance();

    // 6: reset during a store, late completion ignored
    data_req = 1'b1; data_wr = 1'b1; data_addr = 16'h0400; data_wdata = 16'h1111;
    sample(); chk("t6_issue", mem_wr, 1); advance();
    sample(); chk("t6_busy", busy, 1); advance();
    rst = 1'b1; data_req = 1'b0;
    sample(); chk("t6_rst_busy", busy, 0); advance();
    rst = 1'b0; mem_done = 1'b1;
    sample(); chk("t6_no_done", data_done, 0); chk("t6_idle", busy, 0); chk("t6_err_clr", err, 0);
    advance();
    mem_done = 1'b0;

    // Randomized phase
    cnt = 0;
    for (int k = 0; k < 4000; k++) begin
      env_drive();
      sample();
      env_react();
      advance();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
